// File: rtl/led_fb_ram.sv
// ROWS x COLS frame buffer: one-hot point/stroke writes, a hardware clear sweep, and a registered binary read port (1-cycle latency).
// No backpressure: write edges that arrive during CLEAR, during COMMIT, or with a malformed address are dropped.
module led_fb_ram #(
   parameter int             ROWS     = 8,
   parameter int             COLS     = 8,
   parameter int             DW       = 4,
   parameter int             TIMEOUT  = 50_000_000,
   parameter int             TMR_W    = 26,
   parameter logic [DW-1:0]  CLR_VAL  = '0,
   localparam int            RW       = $clog2(ROWS),
   localparam int            CW       = $clog2(COLS)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_mode,
   input  logic              i_clr_req,
   input  logic              i_we,
   input  logic [DW-1:0]     i_wr_data,
   input  logic [ROWS-1:0]   i_wr_row_oh,
   input  logic [COLS-1:0]   i_wr_col_oh,
   input  logic [RW-1:0]     i_rd_row,
   input  logic [CW-1:0]     i_rd_col,
   output logic [DW-1:0]     o_rd_data,
   output logic [RW-1:0]     o_last_row,
   output logic [CW-1:0]     o_last_col,
   output logic              o_busy,
   output logic              o_pend,
   output logic              o_commit
);

   localparam int               N        = ROWS * COLS;
   localparam int               AW       = $clog2(N);
   localparam logic [AW-1:0]    ADDR_END = AW'(N - 1);
   localparam logic [CW-1:0]    COL_END  = CW'(COLS - 1);
   localparam logic [TMR_W-1:0] TMO_END  = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_PEND, S_COMMIT} state_t;

   function automatic logic [RW-1:0] row_bin(input logic [ROWS-1:0] v);
      logic [RW-1:0] b;
      b = '0;
      for (int i = 0; i < ROWS; i++)
         if (v[i]) b = b | RW'(i);
      return b;
   endfunction

   function automatic logic [CW-1:0] col_bin(input logic [COLS-1:0] v);
      logic [CW-1:0] b;
      b = '0;
      for (int i = 0; i < COLS; i++)
         if (v[i]) b = b | CW'(i);
      return b;
   endfunction

   function automatic logic [AW-1:0] addr_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
      return AW'(int'(r) * COLS + int'(c));
   endfunction

   state_t              r_state, w_state_nx;
   logic [DW-1:0]       r_ram [0:N-1];
   logic                r_we_d, r_mode_d;
   logic [AW-1:0]       r_clr_addr;
   logic [DW-1:0]       r_rd_data;
   logic [RW-1:0]       r_last_row;
   logic [CW-1:0]       r_last_col;
   logic                r_pend;
   logic                r_pt_vld;
   logic [RW-1:0]       r_pt_row;
   logic [CW-1:0]       r_pt_col;
   logic [RW-1:0]       r_buf_row;
   logic [DW-1:0]       r_buf_data;
   logic [COLS-1:0]     r_mask;
   logic                r_nxt_vld;
   logic [RW-1:0]       r_nxt_row;
   logic [DW-1:0]       r_nxt_data;
   logic [COLS-1:0]     r_nxt_col_oh;
   logic [TMR_W-1:0]    r_timer;
   logic [CW-1:0]       r_col_idx;

   logic                w_rise, w_fall, w_valid, w_mchg;
   logic [RW-1:0]       w_row_bin;
   logic [CW-1:0]       w_col_bin;
   logic                w_ram_we, w_last_upd, w_commit;
   logic [RW-1:0]       w_wr_row;
   logic [CW-1:0]       w_wr_col;
   logic [DW-1:0]       w_ram_dat;
   logic [AW-1:0]       w_ram_addr, w_rd_addr;

   assign w_rise     = i_we & ~r_we_d;
   assign w_fall     = ~i_we & r_we_d;
   assign w_valid    = $onehot(i_wr_row_oh) && $onehot(i_wr_col_oh);
   assign w_mchg     = i_mode != r_mode_d;
   assign w_row_bin  = row_bin(i_wr_row_oh);
   assign w_col_bin  = col_bin(i_wr_col_oh);
   assign w_rd_addr  = addr_of(i_rd_row, i_rd_col);
   assign w_ram_addr = (r_state == S_CLEAR) ? r_clr_addr : addr_of(w_wr_row, w_wr_col);

   always_comb begin
      w_state_nx = r_state;
      w_ram_we   = 1'b0;
      w_ram_dat  = CLR_VAL;
      w_wr_row   = '0;
      w_wr_col   = '0;
      w_last_upd = 1'b0;
      w_commit   = 1'b0;
      if (r_state == S_CLEAR) begin
         w_ram_we = 1'b1;
         if (i_clr_req)                     w_state_nx = S_CLEAR;
         else if (r_clr_addr == ADDR_END)   w_state_nx = S_IDLE;
      end else if (i_clr_req) begin
         w_state_nx = S_CLEAR;
      end else if (w_mchg) begin
         w_state_nx = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_mode) begin
                  if (w_rise && w_valid) w_state_nx = S_PEND;
               end else if (w_fall && w_valid && r_pt_vld) begin
                  w_ram_we   = 1'b1;
                  w_ram_dat  = i_wr_data;
                  w_wr_row   = r_pt_row;
                  w_wr_col   = r_pt_col;
                  w_last_upd = 1'b1;
               end
            end
            S_PEND: begin
               // A rise beats a same-cycle timeout so the stroke keeps growing.
               if (w_rise && w_valid) begin
                  if (w_row_bin != r_buf_row) w_state_nx = S_COMMIT;
               end else if (r_timer == TMO_END) begin
                  w_state_nx = S_COMMIT;
               end
            end
            S_COMMIT: begin
               w_wr_row = r_buf_row;
               w_wr_col = r_col_idx;
               if (r_mask[r_col_idx]) begin
                  w_ram_we   = 1'b1;
                  w_ram_dat  = r_buf_data;
                  w_last_upd = 1'b1;
               end
               if (r_col_idx == COL_END) begin
                  w_commit   = 1'b1;
                  w_state_nx = r_nxt_vld ? S_PEND : S_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_CLEAR;
      else       r_state <= w_state_nx;
   end

   always_ff @(posedge i_clk) begin
      if (w_ram_we && !i_rst) r_ram[w_ram_addr] <= w_ram_dat;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_we_d       <= 1'b0;
         r_mode_d     <= i_mode;
         r_clr_addr   <= '0;
         r_rd_data    <= '0;
         r_last_row   <= '0;
         r_last_col   <= '0;
         r_pend       <= 1'b0;
         r_pt_vld     <= 1'b0;
         r_pt_row     <= '0;
         r_pt_col     <= '0;
         r_buf_row    <= '0;
         r_buf_data   <= '0;
         r_mask       <= '0;
         r_nxt_vld    <= 1'b0;
         r_nxt_row    <= '0;
         r_nxt_data   <= '0;
         r_nxt_col_oh <= '0;
         r_timer      <= '0;
         r_col_idx    <= '0;
      end else begin
         r_we_d    <= i_we;
         r_mode_d  <= i_mode;
         r_rd_data <= r_ram[w_rd_addr];
         if (w_last_upd) begin
            r_last_row <= w_wr_row;
            r_last_col <= w_wr_col;
         end
         if (r_state == S_CLEAR) begin
            r_clr_addr <= (i_clr_req || r_clr_addr == ADDR_END) ? '0 : r_clr_addr + AW'(1);
         end else if (i_clr_req || w_mchg) begin
            r_clr_addr <= '0;
            r_mask     <= '0;
            r_nxt_vld  <= 1'b0;
            r_pt_vld   <= 1'b0;
            r_pend     <= 1'b0;
            r_col_idx  <= '0;
            r_timer    <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (i_mode) begin
                     if (w_rise && w_valid) begin
                        r_buf_row  <= w_row_bin;
                        r_buf_data <= i_wr_data;
                        r_mask     <= i_wr_col_oh;
                        r_timer    <= '0;
                        r_pend     <= 1'b1;
                     end
                  end else if (w_rise && w_valid) begin
                     r_pt_vld <= 1'b1;
                     r_pt_row <= w_row_bin;
                     r_pt_col <= w_col_bin;
                  end else if (w_fall && w_valid && r_pt_vld) begin
                     r_pt_vld <= 1'b0;
                  end
               end
               S_PEND: begin
                  if (w_rise && w_valid) begin
                     if (w_row_bin == r_buf_row) begin
                        r_mask  <= r_mask | i_wr_col_oh;
                        r_timer <= '0;
                     end else begin
                        r_nxt_vld    <= 1'b1;
                        r_nxt_row    <= w_row_bin;
                        r_nxt_data   <= i_wr_data;
                        r_nxt_col_oh <= i_wr_col_oh;
                        r_col_idx    <= '0;
                     end
                  end else begin
                     r_timer <= r_timer + TMR_W'(1);
                  end
               end
               S_COMMIT: begin
                  if (r_col_idx == COL_END) begin
                     r_col_idx <= '0;
                     if (r_nxt_vld) begin
                        r_buf_row  <= r_nxt_row;
                        r_buf_data <= r_nxt_data;
                        r_mask     <= r_nxt_col_oh;
                        r_timer    <= '0;
                        r_nxt_vld  <= 1'b0;
                     end else begin
                        r_mask <= '0;
                        r_pend <= 1'b0;
                     end
                  end else begin
                     r_col_idx <= r_col_idx + CW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_rd_data  = r_rd_data;
   assign o_last_row = r_last_row;
   assign o_last_col = r_last_col;
   assign o_busy     = (r_state == S_CLEAR);
   assign o_pend     = r_pend;
   assign o_commit   = w_commit;

endmodule

// File: tb/tb_led_fb_ram.sv
// Directed bench for led_fb_ram (8x8, DW=4, TIMEOUT=20): clear sweep, point writes, strokes, aborts.
module tb_led_fb_ram;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mode = 1'b0;
   logic       clr_req = 1'b0;
   logic       we = 1'b0;
   logic [3:0] wr_data = '0;
   logic [7:0] row_oh = '0;
   logic [7:0] col_oh = '0;
   logic [2:0] rd_row = '0;
   logic [2:0] rd_col = '0;
   logic [3:0] rd_data;
   logic [2:0] last_row, last_col;
   logic       busy, pend, commit;

   int n_vec = 0;
   int n_err = 0;

   led_fb_ram #(.ROWS(8), .COLS(8), .DW(4), .TIMEOUT(20), .TMR_W(5), .CLR_VAL(4'h0)) dut (
      .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_clr_req(clr_req), .i_we(we),
      .i_wr_data(wr_data), .i_wr_row_oh(row_oh), .i_wr_col_oh(col_oh),
      .i_rd_row(rd_row), .i_rd_col(rd_col), .o_rd_data(rd_data),
      .o_last_row(last_row), .o_last_col(last_col), .o_busy(busy),
      .o_pend(pend), .o_commit(commit)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_we(input logic lvl, input logic [7:0] r, input logic [7:0] c, input logic [3:0] d);
      row_oh  = r;
      col_oh  = c;
      wr_data = d;
      we      = lvl;
      tick();
   endtask

   task automatic rd(input int r, input int c, output logic [3:0] v);
      rd_row = 3'(r);
      rd_col = 3'(c);
      tick();
      v = rd_data;
   endtask

   task automatic wait_commit(input int lim, output int cnt);
      cnt = 0;
      while (cnt < lim && !commit) begin
         tick();
         cnt++;
      end
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 200) begin
         n++;
         tick();
      end
   endtask

   initial begin
      logic [3:0] v;
      int         cnt;
      int         pulses;

      repeat (3) tick();
      chk_eq("rst_busy", 32'(busy), 1);
      chk_eq("rst_pend", 32'(pend), 0);
      chk_eq("rst_commit", 32'(commit), 0);
      chk_eq("rst_last_row", 32'(last_row), 0);
      chk_eq("rst_last_col", 32'(last_col), 0);
      chk_eq("rst_rd_data", 32'(rd_data), 0);
      rst = 1'b0;
      count_busy(cnt);
      chk_eq("init_busy_len", 32'(cnt), 64);
      for (int i = 0; i < 64; i++) begin
         rd(i / 8, i % 8, v);
         chk_eq("init_clear", 32'(v), 0);
      end

      // point mode
      drive_we(1'b1, 8'h04, 8'h20, 4'h0);
      drive_we(1'b0, 8'h04, 8'h20, 4'hA);
      rd(2, 5, v);
      chk_eq("pt_data", 32'(v), 32'hA);
      chk_eq("pt_last_row", 32'(last_row), 2);
      chk_eq("pt_last_col", 32'(last_col), 5);
      chk_eq("pt_pend", 32'(pend), 0);
      drive_we(1'b1, 8'h04, 8'h21, 4'h0);
      drive_we(1'b0, 8'h04, 8'h21, 4'h3);
      rd(2, 5, v);
      chk_eq("pt_bad_addr", 32'(v), 32'hA);
      rd(2, 0, v);
      chk_eq("pt_bad_addr_c0", 32'(v), 0);
      chk_eq("pt_bad_last_col", 32'(last_col), 5);

      // draw: row 3, cols 1/4/6, timeout commit
      mode = 1'b1;
      tick();
      drive_we(1'b1, 8'h08, 8'h02, 4'h7);
      drive_we(1'b0, 8'h08, 8'h02, 4'h7);
      drive_we(1'b1, 8'h08, 8'h10, 4'hE);
      drive_we(1'b0, 8'h08, 8'h10, 4'hE);
      drive_we(1'b1, 8'h08, 8'h40, 4'hE);
      chk_eq("dr_pend", 32'(pend), 1);
      we = 1'b0;
      wait_commit(100, cnt);
      chk_eq("dr_commit_delay", 32'(cnt), 27);
      tick();
      chk_eq("dr_commit_once", 32'(commit), 0);
      chk_eq("dr_pend_after", 32'(pend), 0);
      chk_eq("dr_last_row", 32'(last_row), 3);
      chk_eq("dr_last_col", 32'(last_col), 6);
      for (int c = 0; c < 8; c++) begin
         rd(3, c, v);
         chk_eq("dr_row3", 32'(v), (c == 1 || c == 4 || c == 6) ? 32'h7 : 32'h0);
      end

      // draw: row change forces an immediate commit
      drive_we(1'b1, 8'h02, 8'h01, 4'h5);
      drive_we(1'b0, 8'h02, 8'h01, 4'h5);
      drive_we(1'b1, 8'h20, 8'h04, 4'h9);
      we = 1'b0;
      wait_commit(50, cnt);
      chk_eq("rc_commit_delay", 32'(cnt), 7);
      tick();
      chk_eq("rc_pend_next", 32'(pend), 1);
      chk_eq("rc_last_row", 32'(last_row), 1);
      chk_eq("rc_last_col", 32'(last_col), 0);
      wait_commit(100, cnt);
      chk_eq("rc_next_delay", 32'(cnt), 27);
      tick();
      chk_eq("rc_pend_done", 32'(pend), 0);
      chk_eq("rc_last_row2", 32'(last_row), 5);
      chk_eq("rc_last_col2", 32'(last_col), 2);
      rd(5, 2, v);
      chk_eq("rc_r5c2", 32'(v), 32'h9);
      rd(1, 0, v);
      chk_eq("rc_r1c0", 32'(v), 32'h5);
      rd(5, 3, v);
      chk_eq("rc_r5c3", 32'(v), 0);

      // mode toggle discards a pending stroke
      drive_we(1'b1, 8'h04, 8'h08, 4'hB);
      drive_we(1'b0, 8'h04, 8'h08, 4'hB);
      chk_eq("mt_pend_before", 32'(pend), 1);
      mode = 1'b0;
      tick();
      chk_eq("mt_pend_after", 32'(pend), 0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (commit) pulses++;
      end
      chk_eq("mt_no_commit", 32'(pulses), 0);
      rd(2, 3, v);
      chk_eq("mt_r2c3", 32'(v), 0);
      rd(2, 5, v);
      chk_eq("mt_r2c5", 32'(v), 32'hA);

      // clear request in the middle of a commit
      mode = 1'b1;
      tick();
      drive_we(1'b1, 8'h10, 8'h01, 4'h6);
      drive_we(1'b0, 8'h10, 8'h01, 4'h6);
      drive_we(1'b1, 8'h10, 8'h80, 4'h6);
      drive_we(1'b0, 8'h10, 8'h80, 4'h6);
      rd_row = 3'd4;
      rd_col = 3'd0;
      drive_we(1'b1, 8'h01, 8'h01, 4'h1);
      we = 1'b0;
      tick();
      tick();
      chk_eq("mc_partial_write", 32'(rd_data), 32'h6);
      chk_eq("mc_last_col", 32'(last_col), 0);
      chk_eq("mc_busy_before", 32'(busy), 0);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      chk_eq("mc_busy_next", 32'(busy), 1);
      chk_eq("mc_pend", 32'(pend), 0);
      count_busy(cnt);
      chk_eq("mc_busy_len", 32'(cnt), 64);
      chk_eq("mc_pend_end", 32'(pend), 0);
      for (int i = 0; i < 64; i++) begin
         rd(i / 8, i % 8, v);
         chk_eq("mc_clear", 32'(v), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
